// File: rtl/uart_tx_if.sv
// Byte producer -> UART transmitter handshake (valid/ready, one byte per accepted edge).
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO ahead of the shift register.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   byte_if,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             bit_end_c;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_c, pop_c;

  // data_ready is a flop, so a pop never opens a slot for a push in the same cycle
  assign push_c    = byte_if.data_valid && byte_if.data_ready;
  assign bit_end_c = (bit_cnt_q == '0);

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Next-state, bit timing and shift control
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop_c     = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = BIT_RELOAD;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_cnt_d = BIT_RELOAD;
          idx_d     = 3'd0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          bit_cnt_d = BIT_RELOAD;
          shift_d   = {1'b0, shift_q[7:1]};
          idx_d     = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          bit_cnt_d = BIT_RELOAD;
          if (count_q != '0) begin
            pop_c   = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value follows the state being entered so tx comes straight from a flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      bit_cnt_q          <= '0;
      idx_q              <= '0;
      shift_q            <= '0;
      tx                 <= 1'b1;
      busy               <= 1'b0;
      count_q            <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      byte_if.data_ready <= 1'b0;
    end else begin
      state_q            <= state_d;
      bit_cnt_q          <= bit_cnt_d;
      idx_q              <= idx_d;
      shift_q            <= shift_d;
      tx                 <= tx_d;
      busy               <= (state_d != IDLE) || (count_d != '0);
      count_q            <= count_d;
      byte_if.data_ready <= (count_d != FULL_CNT);
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= byte_if.data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of accepted bytes checked by a cycle-accurate serial monitor.
module tb_uart_tx;

  localparam int unsigned CPB    = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned FRAME  = 10 * CPB;
  localparam int unsigned BUDGET = 400;

  logic clk;
  logic rst_n;
  logic tx;
  logic busy;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .byte_if (bus),
    .tx      (tx),
    .busy    (busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned frames_done = 0;
  logic [7:0]  exp_q[$];
  int unsigned starts_q[$];

  initial clk = 1'b0;
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial monitor: every cycle of every bit of a frame is checked
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    bit         shape_ok;
    bit         aborted;
    int         bitn;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        starts_q.push_back(cyc);
        got = '0;
        shape_ok = 1'b1;
        aborted = 1'b0;
        for (int s = 1; s < int'(FRAME); s++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bitn = s / int'(CPB);
          if (bitn == 0) shape_ok &= (tx === 1'b0);
          else if (bitn <= 8) begin
            if (s % int'(CPB) == 0) got[bitn-1] = tx;
            else shape_ok &= (tx === got[bitn-1]);
          end else shape_ok &= (tx === 1'b1);
        end
        if (!aborted) begin
          chk("frame_expected", 32'(exp_q.size() > 0), 1);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk("frame_byte", 32'(got), 32'(exp));
          chk("frame_shape", 32'(shape_ok), 1);
          frames_done++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int unsigned n;
    n = 0;
    bus.data_in = b;
    bus.data_valid = 1'b1;
    while (bus.data_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(bus.data_ready), 1);
    if (bus.data_ready === 1'b1) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int unsigned n, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", frames_done, n);
  endtask

  task automatic wait_cyc(input int unsigned target);
    int unsigned k;
    k = 0;
    while (cyc < target && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("sync_cycle", cyc, target);
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while (busy !== 1'b0 && k < 8 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("idle_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #(40 * 100000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned c0;
    int unsigned acc;
    int unsigned k;
    int unsigned base;
    int unsigned lows;

    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.data_ready), 0);
    #5 rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(bus.data_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", 32'(bus.data_ready), 1);

    // Data ignored without valid
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    chk("novalid_busy", 32'(busy), 0);
    chk("novalid_tx", 32'(tx), 1);

    // Single byte 0x41 with first-frame latency
    bus.data_in = 8'h41;
    bus.data_valid = 1'b1;
    chk("single_ready", 32'(bus.data_ready), 1);
    exp_q.push_back(8'h41);
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk("lat_edge_n_tx", 32'(tx), 1);
    chk("lat_edge_n_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_edge_n1_tx", 32'(tx), 0);
    wait_frames(1, 2 * FRAME);
    repeat (2) @(negedge clk);
    chk("single_busy_after", 32'(busy), 0);
    chk("single_tx_after", 32'(tx), 1);

    // Burst with valid held: contiguous frames
    starts_q.delete();
    base = frames_done;
    send(8'h55);
    send(8'hAA);
    send(8'h00);
    send(8'hFF);
    bus.data_valid = 1'b0;
    wait_frames(base + 4, 6 * FRAME);
    chk("burst_starts", starts_q.size(), 4);
    if (starts_q.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("burst_gap", starts_q[i+1] - starts_q[i], FRAME);
      chk("burst_span", starts_q[3] + FRAME - starts_q[0], 4 * FRAME);
    end
    wait_idle();

    // Fill: one byte in the shifter plus DEPTH buffered
    base = frames_done;
    c0 = 0;
    acc = 0;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data_in = 8'hC0 + 8'(acc);
      if (bus.data_ready === 1'b1) begin
        if (acc == 0) c0 = cyc;
        exp_q.push_back(bus.data_in);
        acc++;
      end
      @(negedge clk);
    end
    chk("fill_accepted", acc, 5);
    chk("fill_ready_low", 32'(bus.data_ready), 0);
    bus.data_in = 8'hC5;
    k = 0;
    while (bus.data_ready !== 1'b1 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("fill_ready_rise_cycle", cyc, c0 + 2 + FRAME);
    exp_q.push_back(8'hC5);
    @(negedge clk);
    bus.data_valid = 1'b0;
    wait_frames(base + 6, 8 * FRAME);
    wait_idle();

    // Push coinciding with STOP-end pop at DEPTH-1 occupancy
    base = frames_done;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 8'hD0 + 8'(i);
      bus.data_valid = 1'b1;
      chk("coin_setup_ready", 32'(bus.data_ready), 1);
      exp_q.push_back(bus.data_in);
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    wait_cyc(c0 + 1 + FRAME);
    bus.data_in = 8'hD4;
    bus.data_valid = 1'b1;
    chk("coin_ready_before", 32'(bus.data_ready), 1);
    exp_q.push_back(8'hD4);
    @(negedge clk);
    chk("coin_next_start_tx", 32'(tx), 0);
    chk("coin_ready_after", 32'(bus.data_ready), 1);
    bus.data_in = 8'hD5;
    exp_q.push_back(8'hD5);
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk("coin_full", 32'(bus.data_ready), 0);
    wait_frames(base + 6, 8 * FRAME);
    wait_idle();

    // Reset during data bit 3 with two bytes queued
    base = frames_done;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = 8'h00 + 8'(i);
      bus.data_valid = 1'b1;
      exp_q.push_back(bus.data_in);
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    wait_cyc(c0 + 2 + 4 * CPB + CPB / 2);
    chk("pre_reset_bit3", 32'(tx), 0);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ready", 32'(bus.data_ready), 0);
    exp_q.delete();
    @(negedge clk);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.data_ready), 1);
    lows = 0;
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_frames", frames_done, base);
    send(8'hF7);
    bus.data_valid = 1'b0;
    wait_frames(base + 1, 2 * FRAME);
    wait_idle();

    // All byte values in order
    base = frames_done;
    for (int i = 0; i < 256; i++) send(8'(i));
    bus.data_valid = 1'b0;
    wait_frames(base + 256, 300 * FRAME);
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 217, meaning clock cycles per serial bit (25 MHz / 115200 baud).
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, meaning the number of bytes buffered ahead of the shifter (power of two, at least 2).
REQ-003 The block SHALL have CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have RST_N  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 The block SHALL have DATA_IN  input  8  byte to transmit, sampled on handshake.
REQ-006 The block SHALL have DATA_VALID  input  1  producer offers DATA_IN this cycle.
REQ-007 The block SHALL have DATA_READY  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have TX  output  1  serial line, idle high, driven from a flop.
REQ-009 The block SHALL have BUSY  output  1  frame in flight or FIFO non-empty.

Function
REQ-010 Handshake: a byte SHALL be accepted on a rising edge where DATA_VALID=1 and DATA_READY=1; no other transfer occurs.
REQ-011 DATA_READY SHALL equal "FIFO not full", registered state only, never depending combinationally on DATA_VALID.
REQ-012 Full FIFO: DATA_READY=0; a pop in the same cycle does not enable a push in that cycle.
REQ-013 Accepted bytes SHALL be transmitted strictly in acceptance order; none dropped, none duplicated.
REQ-014 Frame format SHALL be 8N1: start bit 0, DATA bits 0..7 LSB first, stop bit 1.
REQ-015 Each bit SHALL hold TX for exactly CLKS_PER_BIT cycles, counted by a down-counter reloaded at each bit boundary.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: TX=1; FIFO non-empty -> pop head into shift register, go to START.
REQ-018 START: TX=0 for CLKS_PER_BIT cycles -> DATA with bit index 0.
REQ-019 DATA: TX=shift[0]; at bit end shift right and increment index; at index 7 end -> STOP.
REQ-020 STOP: TX=1 for CLKS_PER_BIT cycles; in the last cycle, FIFO non-empty -> pop and go directly to START, else go to IDLE.
REQ-021 Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE -> TX low after edge N+1.
REQ-022 Back-to-back bytes SHALL be sent with no idle gap; period exactly 10*CLKS_PER_BIT cycles.
REQ-023 Push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.
REQ-025 BUSY SHALL be 1 when state != IDLE or FIFO occupancy != 0, else 0.
REQ-026 DATA_IN SHALL be ignored when DATA_VALID=0, and in all cycles other than the handshake edge.

Reset
REQ-027 RST_N=0 SHALL immediately force TX=1, BUSY=0, DATA_READY=0, state=IDLE, FIFO empty, counters and shift register cleared.
REQ-028 DATA_READY SHALL rise on the first rising edge after RST_N deasserts.
REQ-029 Reset mid-frame SHALL abort the frame: TX high at once, buffered bytes discarded, no partial frame resumed.

Verification
REQ-030 Single byte 0x41 at default params, 25 MHz clock -> TX low 8680 ns, then 1,0,0,0,0,0,1,0 at 8680 ns each, stop high; BUSY=0 afterwards.
REQ-031 Burst 0x55,0xAA,0x00,0xFF with DATA_VALID held -> four contiguous frames, 40*CLKS_PER_BIT cycles total, no gap.
REQ-032 FIFO_DEPTH=4, CLKS_PER_BIT=4, DATA_VALID held high -> first pop during idle; 5 bytes accepted; DATA_READY low until next pop; order preserved.
REQ-033 Push coinciding with STOP-end pop at full-1 occupancy -> occupancy unchanged, byte sent later in order.
REQ-034 RST_N pulsed low during DATA bit 3 with 2 bytes queued -> TX=1 asynchronously, BUSY=0; no frame after release until a new byte.
REQ-035 Loopback of TX into the existing UART receiver, 256 bytes 0x00..0xFF -> all received bytes match in order.
